// File: rtl/panel_row_loader_if.sv
// Byte-stream input and chunk-write output bundle for panel_row_loader.
// The master side drives frame_start and the byte stream; the slave side is the loader.
interface panel_row_loader_if;
   logic        frame_start;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic [31:0] chunk_data;
   logic [3:0]  chunk_data_addr;
   logic [3:0]  row_data_row_addr;
   logic        chunk_data_write_enable;
   logic        busy;
   logic        frame_done;
   logic        frame_error;

   modport master (
      output frame_start, byte_in, byte_valid,
      input  byte_ready, chunk_data, chunk_data_addr, row_data_row_addr,
             chunk_data_write_enable, busy, frame_done, frame_error
   );

   modport slave (
      input  frame_start, byte_in, byte_valid,
      output byte_ready, chunk_data, chunk_data_addr, row_data_row_addr,
             chunk_data_write_enable, busy, frame_done, frame_error
   );
endinterface

// File: rtl/panel_row_loader.sv
// panel_row_loader: packs a byte stream big-endian into 32-bit chunks and writes
// them to per-chunk row RAMs, highest chunk address first, row by row.
// Optional feature macro: PANEL_LOADER_CHECKSUM_EN adds a CHECK state that takes
// one trailing byte and compares it with the mod-256 sum of the frame bytes.
module panel_row_loader #(
   parameter int NUM_ROWS       = 16,
   parameter int CHUNKS_PER_ROW = 12
) (
   input  logic              clk,
   input  logic              reset_n,
   panel_row_loader_if.slave bus
);

   localparam logic [3:0] LAST_CHUNK = 4'(CHUNKS_PER_ROW - 1);
   localparam logic [3:0] LAST_ROW   = 4'(NUM_ROWS - 1);

`ifdef PANEL_LOADER_CHECKSUM_EN
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_LOAD} state_t;
`endif

   state_t      state_q, state_d;
   logic [1:0]  lane_q, lane_d;
   logic [23:0] acc_q, acc_d;
   logic [3:0]  chunk_q, chunk_d;
   logic [3:0]  row_q, row_d;
   logic [31:0] data_q, data_d;
   logic        we_q, we_d;
   logic        ready_q, ready_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
`ifdef PANEL_LOADER_CHECKSUM_EN
   logic [7:0]  sum_q, sum_d;
`endif

   logic accept;
   logic last_strobe;

   assign accept      = bus.byte_valid & ready_q;
   // The strobe currently on the bus carries the final chunk of the frame.
   assign last_strobe = we_q & (chunk_q == 4'd0) & (row_q == LAST_ROW);

   // Next-state logic: frame start/abort, byte packing, address stepping and completion.
   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      acc_d   = acc_q;
      chunk_d = chunk_q;
      row_d   = row_q;
      data_d  = data_q;
      we_d    = 1'b0;
      ready_d = ready_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
`ifdef PANEL_LOADER_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      if (bus.frame_start) begin
         // A start outside IDLE aborts the frame in flight; any byte this cycle is dropped.
         err_d   = (state_q != S_IDLE);
         state_d = S_LOAD;
         busy_d  = 1'b1;
         ready_d = 1'b1;
         lane_d  = 2'd0;
         chunk_d = LAST_CHUNK;
         row_d   = 4'd0;
`ifdef PANEL_LOADER_CHECKSUM_EN
         sum_d   = 8'd0;
`endif
      end else if (state_q == S_LOAD) begin
         // Addresses stay put for the strobe cycle and step right after it.
         if (we_q) begin
            if (chunk_q == 4'd0) begin
               chunk_d = LAST_CHUNK;
               row_d   = (row_q == LAST_ROW) ? 4'd0 : row_q + 4'd1;
            end else begin
               chunk_d = chunk_q - 4'd1;
            end
         end
         if (accept) begin
            acc_d = {acc_q[15:0], bus.byte_in};
`ifdef PANEL_LOADER_CHECKSUM_EN
            sum_d = sum_q + bus.byte_in;
`endif
            if (lane_q == 2'd3) begin
               data_d = {acc_q, bus.byte_in};
               we_d   = 1'b1;
               lane_d = 2'd0;
               // Frame payload complete: stop taking bytes until the final strobe retires.
               if ((chunk_q == 4'd0) && (row_q == LAST_ROW)) ready_d = 1'b0;
            end else begin
               lane_d = lane_q + 2'd1;
            end
         end
         if (last_strobe) begin
`ifdef PANEL_LOADER_CHECKSUM_EN
            state_d = S_CHECK;
            ready_d = 1'b1;
`else
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
         end
      end
`ifdef PANEL_LOADER_CHECKSUM_EN
      else if (state_q == S_CHECK) begin
         if (accept) begin
            state_d = S_IDLE;
            ready_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = (bus.byte_in == sum_q);
            err_d   = (bus.byte_in != sum_q);
         end
      end
`endif
   end

   // State and registered outputs; reset abandons any frame without signalling an error.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         lane_q  <= 2'd0;
         acc_q   <= 24'd0;
         chunk_q <= LAST_CHUNK;
         row_q   <= 4'd0;
         data_q  <= 32'd0;
         we_q    <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef PANEL_LOADER_CHECKSUM_EN
         sum_q   <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         acc_q   <= acc_d;
         chunk_q <= chunk_d;
         row_q   <= row_d;
         data_q  <= data_d;
         we_q    <= we_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef PANEL_LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

   assign bus.byte_ready              = ready_q;
   assign bus.chunk_data              = data_q;
   assign bus.chunk_data_addr         = chunk_q;
   assign bus.row_data_row_addr       = row_q;
   assign bus.chunk_data_write_enable = we_q;
   assign bus.busy                    = busy_q;
   assign bus.frame_done              = done_q;
   assign bus.frame_error             = err_q;

endmodule
